// File: rtl/alu16_arbiter_if.sv
// alu16_arbiter_if
//   Requester-side bus of the shared-ALU arbiter. Carries both requesters'
//   handshakes and operands plus the shared registered result fields.
//
//   Signals:
//     req0/req1      request, held high until the matching gnt
//     a0/a1, b0/b1   operands (b is also the shift amount)
//     op0/op1        opcode
//     gnt0/gnt1      one-cycle grant pulse, operands sampled that cycle
//     done0/done1    one-cycle completion pulse for the winning requester
//     result         registered ALU result, held between operations
//     ovfl/zero/err  registered overflow, zero and illegal-opcode flags
//     busy           arbiter is executing or completing an operation
//
//   Modports:
//     master  requester side (drives req/operands, observes the rest)
//     slave   arbiter side
interface alu16_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [OPW-1:0]   op0;
  logic             gnt0;
  logic             done0;

  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [OPW-1:0]   op1;
  logic             gnt1;
  logic             done1;

  logic [WIDTH-1:0] result;
  logic             ovfl;
  logic             zero;
  logic             err;
  logic             busy;

  modport master (
    output req0, a0, b0, op0,
    output req1, a1, b1, op1,
    input  gnt0, done0, gnt1, done1,
    input  result, ovfl, zero, err, busy
  );

  modport slave (
    input  req0, a0, b0, op0,
    input  req1, a1, b1, op1,
    output gnt0, done0, gnt1, done1,
    output result, ovfl, zero, err, busy
  );
endinterface

// File: rtl/alu16_arbiter.sv
// alu16_arbiter
//   Shares one combinational ALU between two requesters. A round-robin
//   pointer picks the winner when both request; the winner's operands are
//   registered and presented to the ALU for one EXEC cycle, the ALU outputs
//   are captured at the end of EXEC, and a one-cycle done pulse is raised
//   for the winner in DONE. Grant in cycle N gives done in cycle N+2.
//
//   Ports:
//     clk                 rising-edge clock
//     reset               synchronous, active-high reset
//     bus (slave)         requester handshakes, operands and result fields
//     alu_a/alu_b/alu_op  operands to the external ALU (registered, held)
//     alu_r               ALU result
//     alu_ovfl/alu_zero   ALU flags
//
//   Optional feature (macro ALU_ARB_STATS_EN):
//     cnt0/cnt1           16-bit wrapping counts of completed operations
//                         per requester, illegal opcodes included.
module alu16_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  alu16_arbiter_if.slave   bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_ovfl,
  input  logic             alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [OPW-1:0] OP_ILLEGAL = '1;

  state_t           state_q;
  logic             prio_q;     // favoured requester when both request
  logic             win_q;      // requester being served
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] result_q;
  logic             ovfl_q;
  logic             zero_q;
  logic             err_q;
  logic             busy_q;
  logic             done0_q;
  logic             done1_q;

  logic             gnt0_d;
  logic             gnt1_d;

`ifdef ALU_ARB_STATS_EN
  logic [15:0]      cnt0_q;
  logic [15:0]      cnt1_q;
`endif

  // Grant is combinational so the requester sees it in the cycle its
  // operands are sampled. Requester 0 wins when alone or when favoured;
  // otherwise any request from requester 1 wins. Masked during reset so
  // the reset cycle shows no grant.
  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (!reset && (state_q == IDLE)) begin
      if (bus.req0 && (!bus.req1 || !prio_q)) begin
        gnt0_d = 1'b1;
      end else if (bus.req1) begin
        gnt1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      win_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      ovfl_q   <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
`ifdef ALU_ARB_STATS_EN
      cnt0_q   <= '0;
      cnt1_q   <= '0;
`endif
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Operand registers only load on a grant, so the ALU inputs
          // stay frozen while idle.
          if (gnt0_d || gnt1_d) begin
            win_q   <= gnt1_d;
            a_q     <= gnt1_d ? bus.a1  : bus.a0;
            b_q     <= gnt1_d ? bus.b1  : bus.b0;
            op_q    <= gnt1_d ? bus.op1 : bus.op0;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_ILLEGAL) begin
            result_q <= '0;
            ovfl_q   <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            result_q <= alu_r;
            ovfl_q   <= alu_ovfl;
            zero_q   <= alu_zero;
            err_q    <= 1'b0;
          end
          done0_q <= ~win_q;
          done1_q <= win_q;
          state_q <= DONE;
        end
        DONE: begin
          prio_q  <= ~win_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef ALU_ARB_STATS_EN
          if (win_q) begin
            cnt1_q <= cnt1_q + 16'd1;
          end else begin
            cnt0_q <= cnt0_q + 16'd1;
          end
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0   = gnt0_d;
  assign bus.gnt1   = gnt1_d;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.ovfl   = ovfl_q;
  assign bus.zero   = zero_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

`ifdef ALU_ARB_STATS_EN
  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu16_arbiter.sv
module tb_alu16_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu16_arbiter_if #(.WIDTH(16), .OPW(3)) bus ();

  logic [15:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_op;
  logic        alu_ovfl, alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  alu16_arbiter #(.WIDTH(16), .OPW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_r    (alu_r),
    .alu_ovfl (alu_ovfl),
    .alu_zero (alu_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  // External ALU. Opcode 111 deliberately produces junk so the arbiter's
  // own illegal-op handling is what the bench observes.
  always_comb begin
    logic [16:0] s;
    s        = '0;
    alu_r    = '0;
    alu_ovfl = 1'b0;
    case (alu_op)
      3'd0: begin s = {1'b0, alu_a} + {1'b0, alu_b}; alu_r = s[15:0]; alu_ovfl = s[16]; end
      3'd1: begin s = {1'b0, alu_a} - {1'b0, alu_b}; alu_r = s[15:0]; alu_ovfl = s[16]; end
      3'd2: alu_r = alu_a & alu_b;
      3'd3: alu_r = alu_a | alu_b;
      3'd4: alu_r = alu_a << alu_b;
      3'd5: alu_r = alu_a >> alu_b;
      3'd6: alu_r = $signed(alu_a) >>> alu_b;
      default: begin alu_r = alu_a ^ alu_b ^ 16'h5A5A; alu_ovfl = 1'b1; end
    endcase
    alu_zero = (alu_r == 16'h0) || (alu_op == 3'd7);
  end

  int checks = 0;
  int errors = 0;
  int exp_prio = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  typedef struct {
    int          who;
    int          wait_c;
    bit          busy1, early, d0, d1, busy2;
    logic [15:0] r, xa, xb;
    logic [2:0]  xop;
    logic        ov, z, e;
  } obs_t;

  // Reference: {err, ovfl, zero, result} from the opcode table with plain
  // integer arithmetic. ovfl is the unsigned carry (add) / borrow (sub).
  function automatic logic [18:0] model(input logic [15:0] a, b, input logic [2:0] op);
    int unsigned ua, ub, r;
    int sa;
    logic ov, er;
    ua = a; ub = b; sa = $signed(a); r = 0; ov = 1'b0; er = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; ov = (r > 65535); end
      3'd1: begin r = ua + 65536 - ub; ov = (ub > ua); end
      3'd2: r = {16'h0, a & b};
      3'd3: r = {16'h0, a | b};
      3'd4: r = (ub > 15) ? 0 : ua * (2 ** ub);
      3'd5: r = (ub > 15) ? 0 : ua / (2 ** ub);
      3'd6: r = (ub > 15) ? ((sa < 0) ? 65535 : 0) : unsigned'(sa >>> ub);
      default: er = 1'b1;
    endcase
    r = r % 65536;
    return {er, ov, (!er && r == 0), r[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant, then records the EXEC and DONE cycles.
  // The winner drops its request the cycle after its grant.
  task automatic serve(output obs_t o);
    o = '{who: -1, wait_c: 0, default: '0};
    for (int c = 0; c < 16; c++) begin
      #1;
      if (bus.gnt0 || bus.gnt1) begin
        o.who = bus.gnt1 ? 1 : 0;
        o.wait_c = c;
        break;
      end
      tick();
    end
    if (o.who < 0) return;
    tick();
    if (o.who == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    #1;
    o.busy1 = bus.busy; o.early = bus.done0 | bus.done1;
    o.xa = alu_a; o.xb = alu_b; o.xop = alu_op;
    tick();
    #1;
    o.d0 = bus.done0; o.d1 = bus.done1; o.busy2 = bus.busy;
    o.r = bus.result; o.ov = bus.ovfl; o.z = bus.zero; o.e = bus.err;
    tick();
    if (o.who == 0) exp_cnt0++; else if (o.who == 1) exp_cnt1++;
    if (o.who >= 0) exp_prio = 1 - o.who;
  endtask

  // Mutual exclusion of the handshake pulses, every cycle.
  always @(negedge clk) begin
    checks++;
    if ((bus.gnt0 && bus.gnt1) || (bus.done0 && bus.done1) ||
        ((bus.gnt0 || bus.gnt1) && (bus.done0 || bus.done1))) begin
      errors++;
      $display("FAIL pulse_exclusive got gnt=%b%b done=%b%b required at most one", bus.gnt1, bus.gnt0, bus.done1, bus.done0);
    end
  end

  task automatic test_reset();
    reset = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick(); tick(); #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.err, bus.ovfl, bus.zero,
         bus.result, alu_a, alu_b, alu_op} !== 59'h0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b%b done=%b%b busy=%b err=%b result=%h a=%h b=%h op=%h required all 0",
               bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.busy, bus.err, bus.result, alu_a, alu_b, alu_op);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    reset = 1'b0; exp_prio = 0; exp_cnt0 = 0; exp_cnt1 = 0;
  endtask

  task automatic test_contested();
    obs_t o;
    bus.req0 = 1'b1; bus.a0 = 16'd1;  bus.b0 = 16'd1; bus.op0 = 3'd1;
    bus.req1 = 1'b1; bus.a1 = 16'd10; bus.b1 = 16'd2; bus.op1 = 3'd1;
    serve(o);
    checks++;
    if (o.who !== 0 || o.r !== 16'h0 || o.z !== 1'b1 || o.d0 !== 1'b1) begin
      errors++;
      $display("FAIL contest_first got who=%0d r=%h z=%b d0=%b required who=0 r=0000 z=1 d0=1", o.who, o.r, o.z, o.d0);
    end
    // Requester 0 returns straight away; the pointer now favours requester 1.
    bus.req0 = 1'b1; bus.a0 = 16'd3; bus.b0 = 16'd4; bus.op0 = 3'd0;
    serve(o);
    checks++;
    if (o.who !== 1 || o.wait_c !== 0 || o.r !== 16'd8 || o.d1 !== 1'b1) begin
      errors++;
      $display("FAIL contest_second got who=%0d wait=%0d r=%h d1=%b required who=1 wait=0 r=0008 d1=1", o.who, o.wait_c, o.r, o.d1);
    end
    serve(o);
    checks++;
    if (o.who !== 0 || o.wait_c !== 0 || o.r !== 16'd7) begin
      errors++;
      $display("FAIL contest_third got who=%0d wait=%0d r=%h required who=0 wait=0 r=0007", o.who, o.wait_c, o.r);
    end
  endtask

  task automatic test_basic();
    obs_t o;
    bus.req0 = 1'b1; bus.a0 = 16'd10; bus.b0 = 16'd2; bus.op0 = 3'd0;
    serve(o);
    checks++;
    if (o.who !== 0 || o.wait_c !== 0 || o.busy1 !== 1'b1 || o.early !== 1'b0 ||
        o.d0 !== 1'b1 || o.d1 !== 1'b0 || o.busy2 !== 1'b1) begin
      errors++;
      $display("FAIL add_timing got who=%0d wait=%0d busy=%b%b early=%b done=%b%b required 0 0 busy=11 early=0 done=01",
               o.who, o.wait_c, o.busy1, o.busy2, o.early, o.d1, o.d0);
    end
    checks++;
    if (o.r !== 16'd12 || o.ov !== 1'b0 || o.z !== 1'b0 || o.e !== 1'b0) begin
      errors++;
      $display("FAIL add_result got r=%h ov=%b z=%b e=%b required r=000c ov=0 z=0 e=0", o.r, o.ov, o.z, o.e);
    end
    checks++;
    if (o.xa !== 16'd10 || o.xb !== 16'd2 || o.xop !== 3'd0) begin
      errors++;
      $display("FAIL add_alu_in got a=%h b=%h op=%h required 000a 0002 0", o.xa, o.xb, o.xop);
    end
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.result !== 16'd12 || alu_a !== 16'd10) begin
      errors++;
      $display("FAIL add_hold got busy=%b done0=%b result=%h alu_a=%h required 0 0 000c 000a", bus.busy, bus.done0, bus.result, alu_a);
    end
    bus.req1 = 1'b1; bus.a1 = 16'hFFFF; bus.b1 = 16'd1; bus.op1 = 3'd0;
    serve(o);
    checks++;
    if (o.who !== 1 || o.d1 !== 1'b1 || o.r !== 16'h0 || o.ov !== 1'b1) begin
      errors++;
      $display("FAIL add_carry got who=%0d d1=%b r=%h ov=%b required 1 1 0000 1", o.who, o.d1, o.r, o.ov);
    end
    bus.req1 = 1'b1; bus.a1 = 16'h803F; bus.b1 = 16'd2; bus.op1 = 3'd6;
    serve(o);
    checks++;
    if (o.who !== 1 || o.r !== 16'hE00F || o.ov !== 1'b0 || o.e !== 1'b0) begin
      errors++;
      $display("FAIL sra got who=%0d r=%h ov=%b e=%b required 1 e00f 0 0", o.who, o.r, o.ov, o.e);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    bus.req0 = 1'b1; bus.a0 = 16'h1234; bus.b0 = 16'h00F0; bus.op0 = 3'd7;
    serve(o);
    checks++;
    if (o.who !== 0 || o.e !== 1'b1 || o.r !== 16'h0 || o.ov !== 1'b0 || o.z !== 1'b0 || o.d0 !== 1'b1) begin
      errors++;
      $display("FAIL illegal got who=%0d e=%b r=%h ov=%b z=%b d0=%b required 0 1 0000 0 0 1", o.who, o.e, o.r, o.ov, o.z, o.d0);
    end
    bus.req0 = 1'b1; bus.a0 = 16'd4; bus.b0 = 16'd1; bus.op0 = 3'd4;
    serve(o);
    checks++;
    if (o.r !== 16'd8 || o.e !== 1'b0) begin
      errors++;
      $display("FAIL sll_after_illegal got r=%h e=%b required 0008 0", o.r, o.e);
    end
  endtask

  task automatic test_drop();
    int g = 0;
    bus.req0 = 1'b1; bus.a0 = 16'h00FF; bus.b0 = 16'h0F0F; bus.op0 = 3'd2;
    tick();
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.a1 = 16'h7777; bus.b1 = 16'd1; bus.op1 = 3'd0;
    #1; g += bus.gnt1;
    tick();
    #1; g += bus.gnt1;
    checks++;
    if (bus.done0 !== 1'b1 || bus.result !== 16'h000F) begin
      errors++;
      $display("FAIL drop_served got done0=%b result=%h required 1 000f", bus.done0, bus.result);
    end
    tick();
    bus.req1 = 1'b0;
    exp_cnt0++; exp_prio = 1;
    for (int i = 0; i < 3; i++) begin
      #1; g += bus.gnt0 + bus.gnt1 + bus.busy;
      tick();
    end
    checks++;
    if (g !== 0 || alu_a !== 16'h00FF) begin
      errors++;
      $display("FAIL drop_no_op got activity=%0d alu_a=%h required 0 00ff", g, alu_a);
    end
  endtask

  task automatic test_reset_exec();
    obs_t o;
    bus.req0 = 1'b1; bus.a0 = 16'd9; bus.b0 = 16'd9; bus.op0 = 3'd3;
    serve(o);
    bus.req0 = 1'b1; bus.a0 = 16'd5; bus.b0 = 16'd6; bus.op0 = 3'd0;
    bus.req1 = 1'b1; bus.a1 = 16'd7; bus.b1 = 16'd1; bus.op1 = 3'd1;
    #1;
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_gnt got gnt=%b%b required 10", bus.gnt1, bus.gnt0);
    end
    tick();
    reset = 1'b1;
    tick(); #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.err, bus.ovfl, bus.zero,
         bus.result, alu_a, alu_b, alu_op} !== 59'h0) begin
      errors++;
      $display("FAIL rst_in_exec got done=%b%b busy=%b result=%h a=%h b=%h op=%h required all 0",
               bus.done1, bus.done0, bus.busy, bus.result, alu_a, alu_b, alu_op);
    end
    reset = 1'b0; exp_prio = 0; exp_cnt0 = 0; exp_cnt1 = 0;
    serve(o);
    checks++;
    if (o.who !== 0 || o.wait_c !== 0 || o.r !== 16'd11) begin
      errors++;
      $display("FAIL rst_regrant got who=%0d wait=%0d r=%h required 0 0 000b", o.who, o.wait_c, o.r);
    end
    serve(o);
    checks++;
    if (o.who !== 1 || o.r !== 16'd6) begin
      errors++;
      $display("FAIL rst_second got who=%0d r=%h required 1 0006", o.who, o.r);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [18:0] exp0, exp1, e;
    logic [15:0] ea, eb;
    logic [2:0] eop;
    bit p0, p1;
    int ew;
    for (int it = 0; it < 40; it++) begin
      p0 = 1'b0; p1 = 1'b0;
      case ($urandom_range(1, 3))
        1: p0 = 1'b1;
        2: p1 = 1'b1;
        default: begin p0 = 1'b1; p1 = 1'b1; end
      endcase
      bus.a0 = 16'($urandom); bus.op0 = 3'($urandom_range(0, 7));
      bus.b0 = (bus.op0 >= 3'd4) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      bus.a1 = 16'($urandom); bus.op1 = 3'($urandom_range(0, 7));
      bus.b1 = (bus.op1 >= 3'd4) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.b0 = bus.a0;
      exp0 = model(bus.a0, bus.b0, bus.op0);
      exp1 = model(bus.a1, bus.b1, bus.op1);
      bus.req0 = p0; bus.req1 = p1;
      while (p0 || p1) begin
        ew  = (p0 && p1) ? exp_prio : (p0 ? 0 : 1);
        e   = (ew == 0) ? exp0 : exp1;
        ea  = (ew == 0) ? bus.a0 : bus.a1;
        eb  = (ew == 0) ? bus.b0 : bus.b1;
        eop = (ew == 0) ? bus.op0 : bus.op1;
        serve(o);
        checks++;
        if (o.who !== ew || o.wait_c !== 0 || o.busy1 !== 1'b1 || o.early !== 1'b0 ||
            o.busy2 !== 1'b1 || o.d0 !== (ew == 0) || o.d1 !== (ew == 1)) begin
          errors++;
          $display("FAIL rand_handshake it=%0d got who=%0d wait=%0d busy=%b%b done=%b%b required who=%0d wait=0 busy=11 one done",
                   it, o.who, o.wait_c, o.busy1, o.busy2, o.d1, o.d0, ew);
        end
        checks++;
        if ({o.e, o.ov, o.z, o.r} !== e || o.xa !== ea || o.xb !== eb || o.xop !== eop) begin
          errors++;
          $display("FAIL rand_result it=%0d a=%h b=%h op=%0d got e=%b ov=%b z=%b r=%h alu=%h/%h/%0d required e=%b ov=%b z=%b r=%h",
                   it, ea, eb, eop, o.e, o.ov, o.z, o.r, o.xa, o.xb, o.xop, e[18], e[17], e[16], e[15:0]);
        end
        if (o.who < 0) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0; p0 = 1'b0; p1 = 1'b0;
        end else if (o.who == 0) p0 = 1'b0;
        else p1 = 1'b0;
      end
    end
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    obs_t o;
    reset = 1'b1; tick(); reset = 1'b0;
    exp_prio = 0; exp_cnt0 = 0; exp_cnt1 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin bus.req0 = 1'b1; bus.a0 = 16'(i); bus.b0 = 16'd1; bus.op0 = (i == 2) ? 3'd7 : 3'd0; end
      else begin bus.req1 = 1'b1; bus.a1 = 16'(i); bus.b1 = 16'd1; bus.op1 = 3'd1; end
      serve(o);
    end
    checks++;
    if (cnt0 !== 16'(exp_cnt0) || cnt1 !== 16'(exp_cnt1) || exp_cnt0 != 3 || exp_cnt1 != 2) begin
      errors++;
      $display("FAIL stats_count got cnt0=%0d cnt1=%0d required 3 2", cnt0, cnt1);
    end
    force dut.cnt0_q = 16'hFFFF;
    #1;
    release dut.cnt0_q;
    bus.req0 = 1'b1; bus.a0 = 16'd1; bus.b0 = 16'd1; bus.op0 = 3'd0;
    serve(o);
    checks++;
    if (cnt0 !== 16'h0000) begin
      errors++;
      $display("FAIL stats_wrap got cnt0=%h required 0000", cnt0);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.op0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.op1 = '0;
    test_reset();
    test_contested();
    test_basic();
    test_illegal();
    test_drop();
    test_reset_exec();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu16_arbiter.md
Name: alu16_arbiter

Overview:
- Shares one 16-bit ALU datapath between two independent requesters (e.g. main datapath and address/branch unit).
- Arbitrates with round-robin priority, registers the winner's operands, drives the ALU for one cycle, captures r/ovfl/zero, and returns the result with a one-cycle done pulse.
- Sits between requesters and the ALU instance; the ALU stays purely combinational.

Parameters:
- WIDTH, 16, operand/result width.
- OPW, 3, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request; held high until gnt0.
- a0  in  WIDTH  requester 0 operand a.
- b0  in  WIDTH  requester 0 operand b / shift amount.
- op0  in  OPW  requester 0 opcode.
- gnt0  out  1  one-cycle pulse; a0/b0/op0 sampled this cycle.
- done0  out  1  one-cycle pulse; result fields valid for requester 0.
- req1, a1, b1, op1, gnt1, done1: same as above, for requester 1.
- result  out  WIDTH  registered ALU result, valid while done0|done1, held otherwise.
- ovfl  out  1  registered ALU overflow.
- zero  out  1  registered ALU zero flag.
- err  out  1  registered illegal-opcode flag.
- busy  out  1  high in EXEC and DONE.
- alu_a, alu_b  out  WIDTH  to ALU a/b.
- alu_op  out  OPW  to ALU op.
- alu_r  in  WIDTH  from ALU r.
- alu_ovfl, alu_zero  in  1  from ALU.

Behaviour:
- Opcodes: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 srl, 110 sra, 111 illegal.
- Reset: state=IDLE, prio pointer=0 (requester 0 favoured).
  - gnt*, done*, busy, err = 0; result=0, ovfl=0, zero=0.
  - alu_a, alu_b, alu_op = 0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any req is high, pick the winner: sole requester, or the prio side if both request.
  - Assert gnt<w> combinationally in the same cycle.
  - Register a, b, op and the winner id; go to EXEC.
  - No request: stay in IDLE, no gnt.
- EXEC (1 cycle):
  - alu_a/alu_b/alu_op driven from the registered operands.
  - At the clock edge, capture alu_r, alu_ovfl, alu_zero into result/ovfl/zero.
  - If op==111: skip the ALU capture; result=0, ovfl=0, zero=0, err=1. Otherwise err=0.
  - Go to DONE.
- DONE (1 cycle):
  - done<winner>=1.
  - prio <= other requester.
  - Go to IDLE.
- Latency: gnt in cycle N, done in cycle N+2. Back-to-back grants at most every 3 cycles.
- ALU inputs hold the last operands outside EXEC; no toggling in IDLE.
- gnt and done are never high for both requesters at once, and never in the same cycle as each other.
- req dropped before gnt: no operation, no state change.
- req held high through done: treated as a new request in the next IDLE cycle, subject to round-robin.
- Simultaneous req0 and req1 with prio=0: requester 0 wins. The next contested grant goes to requester 1.
- Uncontested requests do not alter fairness beyond the DONE update.
- Reset asserted in EXEC or DONE: the operation is aborted, no done pulse, all outputs go to reset values at that edge.
- result/ovfl/zero/err hold their last value until the next EXEC capture.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs cnt0 and cnt1 (16 bits each): completed operations per requester.
  - Incremented in DONE; wrap 16'hFFFF->0.
  - Cleared by reset; illegal ops are counted.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- req0, a0=10, b0=2, op0=000 alone -> gnt0 in cycle N; done0 in N+2 with result=12, ovfl=0, zero=0; busy high in N+1..N+2.
- req0 and req1 together, both sub; a0=b0=1, a1=10, b1=2 -> requester 0 served first (result=0, zero=1). Requester 1 granted in the following IDLE cycle (result=8). Next contested round goes to requester 1 first.
- req1, a1=16'hFFFF, b1=1, op1=000 -> done1 with result=0, ovfl=1. Then a1=16'h803F, b1=2, op1=110 -> result=16'hE00F.
- req0 with op0=111 -> done0 with err=1, result=0. A following legal sll with a=4, b=1 -> result=8, err=0.
- Reset pulsed in EXEC -> no done pulse; all outputs 0 on the next cycle; pending req re-granted from IDLE with prio=0.
- ALU_ARB_STATS_EN: 3 ops on requester 0 and 2 on requester 1 -> cnt0=3, cnt1=2. Preload cnt0=16'hFFFF by forcing, one op -> cnt0=0.
